// File: rtl/addsub_rr_arbiter.sv
// Round-robin front end that time-shares one external 4-bit add/sub unit among
// NUM_REQ requesters and returns each result with its requester ID.
module addsub_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [4*NUM_REQ-1:0]   i_req_a,
  input  logic [4*NUM_REQ-1:0]   i_req_b,
  input  logic [NUM_REQ-1:0]     i_req_mode,
  output logic [3:0]             o_alu_a,
  output logic [3:0]             o_alu_b,
  output logic                   o_alu_mode,
  input  logic [3:0]             i_alu_result,
  input  logic                   i_alu_cout,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [3:0]             o_rsp_result,
  output logic                   o_rsp_cout,
  output logic                   o_rsp_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [3:0]        r_alu_a;
  logic [3:0]        r_alu_b;
  logic              r_alu_mode;
  logic [ID_W-1:0]   r_rsp_id;
  logic [3:0]        r_rsp_result;
  logic              r_rsp_cout;
  logic              r_rsp_ovf;

  logic [ID_W-1:0]   w_cand [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_valid;
  logic [3:0]        w_a [NUM_REQ];
  logic [3:0]        w_b [NUM_REQ];
  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_accept;

  // w_cand[k] is the requester examined k-th, starting just after the last grant
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_cand[gi]       = ID_W'((32'(r_last_grant) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
      assign w_cand_valid[gi] = i_req_valid[w_cand[gi]];
      assign w_a[gi]          = i_req_a[4*gi +: 4];
      assign w_b[gi]          = i_req_b[4*gi +: 4];
      assign o_req_ready[gi]  = (r_state == S_IDLE) && w_grant_vld && (w_grant_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the back so the earliest valid candidate wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_valid[k]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand[k];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_mode   <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_a[w_grant_id];
        r_alu_b      <= w_b[w_grant_id];
        r_alu_mode   <= i_req_mode[w_grant_id];
        r_rsp_id     <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == S_EXEC) begin
        r_rsp_result <= i_alu_result;
        r_rsp_cout   <= i_alu_cout;
        // Subtract flips B's sign: overflow when effective operand signs agree but result sign differs
        r_rsp_ovf    <= (r_alu_a[3] == (r_alu_b[3] ^ r_alu_mode)) && (i_alu_result[3] != r_alu_a[3]);
      end
    end
  end

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_mode   = r_alu_mode;
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_cout   = r_rsp_cout;
  assign o_rsp_ovf    = r_rsp_ovf;

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 4-bit adder/subtractor datapath among NUM_REQ requesters. It accepts one operation at a time through a per-requester valid/ready handshake and latches the operands. It drives the shared unit, captures result, carry-out and signed overflow, and returns them on a single response channel tagged with the requester ID. It sits between client blocks and the external adder/subtractor instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_a  input  4*NUM_REQ  operand A, requester i at bits [4i+3:4i]
req_b  input  4*NUM_REQ  operand B, same packing
req_mode  input  NUM_REQ  0 = add, 1 = subtract (A-B)
alu_a  output  4  operand A to shared unit
alu_b  output  4  operand B to shared unit
alu_mode  output  1  mode to shared unit
alu_result  input  4  result from shared unit (combinational in alu_* outputs)
alu_cout  input  1  carry-out from shared unit (sub: 1 = no borrow)
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  ID_W  index of requester that issued the operation
rsp_result  output  4  captured result
rsp_cout  output  1  captured carry-out
rsp_ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous, active-low.
- Reset values: state=IDLE; alu_a, alu_b, alu_mode = 0; rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
- State machine, registered state: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, arbitration:
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - The first i in that order with req_valid[i]=1 gets req_ready[i]=1. req_ready is combinational from req_valid and state, and is 0 outside IDLE.
  - A transfer happens when req_valid[i] && req_ready[i]. On that edge: latch A, B and mode into alu_a/alu_b/alu_mode; latch i into rsp_id and last_grant; go to EXEC.
  - If no request is valid, stay in IDLE and keep last_grant.
- EXEC:
  - alu_* hold the latched operands.
  - At the edge: rsp_result <= alu_result; rsp_cout <= alu_cout.
  - rsp_ovf <= (alu_a[3] == (alu_b[3] ^ alu_mode)) && (alu_result[3] != alu_a[3]).
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_* stay stable until rsp_valid && rsp_ready.
  - On that edge: go to IDLE with rsp_valid=0.
  - alu_* keep their last value; they are not cleared.
- Latency and throughput:
  - Accept at edge N gives rsp_valid at N+2.
  - With rsp_ready held high: one operation per 3 cycles, and the next grant can occur in the cycle after the response handshake.
- Fairness: after serving requester i, i has lowest priority. With all requesters continuously valid, grants follow 0,1,2,3,0,...
- Backpressure: while rsp_ready=0, the block stays in RESP indefinitely and all req_ready stay 0. Requesters must hold valid and data until accepted.
- Requester rules:
  - Deasserting req_valid before acceptance withdraws the request without side effects.
  - Operand changes while valid and not ready are legal; the values on the accept edge are used.
- Arithmetic: 4-bit wrap-around. The result is not saturated; overflow is flagged only.
- Reset mid-operation: asynchronous return to reset values. Any in-flight operation is dropped with no response. Priority restarts at requester 0.
- Out-of-range indices (i >= NUM_REQ) are never granted.

Test Plan:
- Single add: req_valid[1]=1, A=3, B=4, mode=0 -> req_ready[1] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=1, result=7, cout=0, ovf=0.
- Subtract with borrow and overflow:
  - req 2, A=2, B=5, mode=1 -> result=0xD, cout=0, ovf=0.
  - req 0, A=7 (+7), B=0xF (-1), mode=1 -> result=8, cout=0, ovf=1.
- Round-robin: all four requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0 and a response every 3 cycles; no requester is granted twice before all others are served.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, all req_ready=0; raise rsp_ready -> one handshake, then the next grant.
- Add overflow and carry:
  - A=0x7, B=0x1, add -> result=8, ovf=1, cout=0.
  - A=0xF, B=0x1, add -> result=0, cout=1, ovf=0.
- Async reset: assert rst_n=0 in EXEC, mid-cycle -> outputs go to 0 immediately with no clock edge; after release, no stale rsp_valid and the first grant goes to requester 0.
